// File: rtl/risc_datapath_if.sv
// Controller-strobe and memory-bus bundle between the 8-phase controller,
// the datapath and the program/data memory.
interface risc_datapath_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);
  logic              sel;
  logic              rd;
  logic              ld_ir;
  logic              halt;
  logic              inc_pc;
  logic              ld_ac;
  logic              ld_pc;
  logic              wr;
  logic              data_e;
  logic [2:0]        phase;
  logic [2:0]        opcode;
  logic              zero;
  logic [AWIDTH-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;

  modport slave (
    input  sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, mem_rdata,
    output phase, opcode, zero, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, mem_rdata,
    input  phase, opcode, zero, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/risc_datapath.sv
// Datapath and phase sequencer for the 8-phase accumulator CPU: PC, IR,
// accumulator, ALU and address mux, driven by the controller's strobes.
module risc_datapath #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  risc_datapath_if.slave     bus,
  output logic               halted,
  output logic [AWIDTH-1:0]  pc_dbg,
  output logic [DWIDTH-1:0]  ac_dbg
);

  localparam logic [2:0]        OP_ADD = 3'b010;
  localparam logic [2:0]        OP_AND = 3'b011;
  localparam logic [2:0]        OP_XOR = 3'b100;
  localparam logic [2:0]        OP_LDA = 3'b101;
  localparam logic [AWIDTH-1:0] PC_ONE = AWIDTH'(1);

  logic [2:0]        phase_q, phase_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [DWIDTH-1:0] ac_q, ac_d;
  logic              halted_q, halted_d;
  logic [AWIDTH-1:0] operand;
  logic [2:0]        opcode;

  // Non-ALU opcodes (HLT, SKZ, STO, JMP) leave the accumulator as is.
  function automatic logic [DWIDTH-1:0] alu(input logic [2:0]        op,
                                            input logic [DWIDTH-1:0] a,
                                            input logic [DWIDTH-1:0] b);
    logic [DWIDTH-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_LDA:  r = b;
      default: r = a;
    endcase
    return r;
  endfunction

  assign operand = ir_q[AWIDTH-1:0];
  assign opcode  = ir_q[DWIDTH-1 -: 3];

  always_comb begin
    phase_d  = phase_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ac_d     = ac_q;
    halted_d = halted_q;
    // The halt edge itself still commits loads; only the phase holds.
    if (!halted_q) begin
      if (bus.halt) halted_d = 1'b1;
      else          phase_d  = phase_q + 3'd1;
      if (bus.ld_ir) ir_d = bus.mem_rdata;
      if (bus.ld_pc)       pc_d = operand;
      else if (bus.inc_pc) pc_d = pc_q + PC_ONE;
      if (bus.ld_ac) ac_d = alu(opcode, ac_q, bus.mem_rdata);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= '0;
      pc_q     <= '0;
      ir_q     <= '0;
      ac_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ac_q     <= ac_d;
      halted_q <= halted_d;
    end
  end

  assign bus.phase     = phase_q;
  assign bus.opcode    = opcode;
  assign bus.zero      = (ac_q == '0);
  assign bus.mem_addr  = bus.sel ? pc_q : operand;
  assign bus.mem_re    = bus.rd & ~halted_q;
  assign bus.mem_we    = bus.wr & ~halted_q;
  assign bus.mem_wdata = bus.data_e ? ac_q : '0;

  assign halted = halted_q;
  assign pc_dbg = pc_q;
  assign ac_dbg = ac_q;

endmodule

// File: tb/tb_risc_datapath.sv
// Self-checking bench for risc_datapath: directed instruction scenarios plus
// randomized strobes against an arithmetic reference model.
module tb_risc_datapath;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          halted;
  logic [AW-1:0] pc_dbg;
  logic [DW-1:0] ac_dbg;

  risc_datapath_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  risc_datapath #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .halted (halted),
    .pc_dbg (pc_dbg),
    .ac_dbg (ac_dbg)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [32];
  assign bus.mem_rdata = mem[bus.mem_addr];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int m_phase, m_pc, m_ir, m_ac;
  bit m_halted;

  task automatic clear_strobes();
    bus.sel = 1'b0; bus.rd = 1'b0; bus.ld_ir = 1'b0; bus.halt = 1'b0;
    bus.inc_pc = 1'b0; bus.ld_ac = 1'b0; bus.ld_pc = 1'b0;
    bus.wr = 1'b0; bus.data_e = 1'b0;
  endtask

  task automatic model_reset();
    m_phase = 0; m_pc = 0; m_ir = 0; m_ac = 0; m_halted = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  // One clock: model next state from the strobes, memory write from DUT bus.
  task automatic tick();
    int a, rdv, nphase, npc, nir, nac;
    bit nh, we;
    logic [4:0] waddr;
    logic [7:0] wdata;
    a = bus.sel ? m_pc : (m_ir % 32);
    rdv = int'(mem[a]);
    nphase = m_phase; npc = m_pc; nir = m_ir; nac = m_ac; nh = m_halted;
    if (!m_halted) begin
      if (bus.halt) nh = 1; else nphase = (m_phase + 1) % 8;
      if (bus.ld_ir) nir = rdv;
      if (bus.ld_pc) npc = m_ir % 32;
      else if (bus.inc_pc) npc = (m_pc + 1) % 32;
      if (bus.ld_ac)
        case (m_ir / 32)
          2: nac = (m_ac + rdv) % 256;
          3: nac = m_ac & rdv;
          4: nac = m_ac ^ rdv;
          5: nac = rdv;
          default: nac = m_ac;
        endcase
    end
    we = bus.mem_we; waddr = bus.mem_addr; wdata = bus.mem_wdata;
    @(posedge clk);
    #1;
    if (we) mem[waddr] = wdata;
    m_phase = nphase; m_pc = npc; m_ir = nir; m_ac = nac; m_halted = nh;
  endtask

  task automatic load_ir(input logic [7:0] v);
    clear_strobes();
    mem[m_pc] = v;
    bus.sel = 1'b1; bus.ld_ir = 1'b1;
    tick();
    clear_strobes();
  endtask

  task automatic load_ac(input logic [7:0] v);
    load_ir(8'hBC);
    mem[28] = v;
    bus.ld_ac = 1'b1;
    tick();
    clear_strobes();
  endtask

  task automatic set_pc(input logic [4:0] v);
    load_ir({3'b000, v});
    bus.ld_pc = 1'b1;
    tick();
    clear_strobes();
  endtask

  // Controller behaviour: one full 8-phase instruction starting at phase 0.
  task automatic run_instr();
    int guard, op;
    guard = 0;
    clear_strobes();
    while (m_phase != 0 && guard < 16) begin
      tick();
      guard++;
    end
    vectors++;
    if (bus.phase !== 3'd0) begin
      miscompares++;
      $display("FAIL run_instr_align phase got %0d need 0", bus.phase);
      return;
    end
    for (int p = 0; p < 8; p++) begin
      clear_strobes();
      op = m_ir / 32;
      bus.sel = (p < 4);
      bus.rd = (p < 4);
      bus.ld_ir = (p == 2);
      bus.inc_pc = (p == 4);
      bus.halt = (p == 4 && op == 0);
      if (op >= 2 && op <= 5) begin
        bus.rd = (p >= 5) || (p < 4);
        bus.ld_ac = (p == 7);
      end
      if (op == 1 && p == 6 && m_ac == 0) bus.inc_pc = 1'b1;
      if (op == 6) begin
        bus.data_e = (p >= 6);
        bus.wr = (p == 7);
      end
      if (op == 7 && p == 6) bus.ld_pc = 1'b1;
      tick();
      if (m_halted) break;
    end
    clear_strobes();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if (bus.phase !== 3'd0 || pc_dbg !== 5'd0 || ac_dbg !== 8'd0 || bus.zero !== 1'b1 ||
        halted !== 1'b0 || bus.opcode !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_values phase=%0d pc=%0h ac=%0h zero=%b halted=%b op=%0d need 0,0,0,1,0,0",
               bus.phase, pc_dbg, ac_dbg, bus.zero, halted, bus.opcode);
    end
    load_ac(8'h3C);
    set_pc(5'd7);
    for (int g = 0; g < 16 && m_phase != 5; g++) tick();
    vectors++;
    if (bus.phase !== 3'd5 || ac_dbg !== 8'h3C || pc_dbg !== 5'd7) begin
      miscompares++;
      $display("FAIL reset_setup phase=%0d ac=%0h pc=%0h need 5,3c,7", bus.phase, ac_dbg, pc_dbg);
    end
    bus.inc_pc = 1'b1; bus.ld_ac = 1'b1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.phase !== 3'd0 || pc_dbg !== 5'd0 || ac_dbg !== 8'd0 || bus.zero !== 1'b1 || halted !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async phase=%0d pc=%0h ac=%0h zero=%b halted=%b need 0,0,0,1,0",
               bus.phase, pc_dbg, ac_dbg, bus.zero, halted);
    end
    clear_strobes();
    model_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      vectors++;
      if (bus.phase !== 3'(k % 8)) begin
        miscompares++;
        $display("FAIL reset_phase_seq step %0d got %0d need %0d", k, bus.phase, k % 8);
      end
    end
  endtask

  task automatic test_add();
    do_reset();
    load_ac(8'h22);
    mem[0] = 8'h45; mem[5] = 8'h10;
    run_instr();
    vectors++;
    if (bus.opcode !== 3'b010 || pc_dbg !== 5'd1 || ac_dbg !== 8'h32) begin
      miscompares++;
      $display("FAIL add_basic op=%0d pc=%0h ac=%0h need 2,1,32", bus.opcode, pc_dbg, ac_dbg);
    end
    load_ac(8'hF0);
    mem[1] = 8'h45; mem[5] = 8'h20;
    run_instr();
    vectors++;
    if (ac_dbg !== 8'h10 || pc_dbg !== 5'd2) begin
      miscompares++;
      $display("FAIL add_carry ac=%0h pc=%0h need 10,2", ac_dbg, pc_dbg);
    end
  endtask

  task automatic test_sto();
    do_reset();
    load_ac(8'hA5);
    load_ir(8'hC9);
    mem[9] = 8'h00;
    bus.sel = 1'b0;
    #1;
    vectors++;
    if (bus.mem_wdata !== 8'h00) begin
      miscompares++;
      $display("FAIL sto_wdata_idle got %0h need 0", bus.mem_wdata);
    end
    bus.data_e = 1'b1;
    #1;
    vectors++;
    if (bus.mem_wdata !== 8'hA5 || bus.mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL sto_phase6 wdata=%0h we=%b need a5,0", bus.mem_wdata, bus.mem_we);
    end
    tick();
    bus.wr = 1'b1;
    #1;
    vectors++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 5'd9 || bus.mem_wdata !== 8'hA5) begin
      miscompares++;
      $display("FAIL sto_write we=%b addr=%0d wdata=%0h need 1,9,a5", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    tick();
    clear_strobes();
    #1;
    vectors++;
    if (bus.mem_we !== 1'b0 || mem[9] !== 8'hA5 || bus.mem_wdata !== 8'h00) begin
      miscompares++;
      $display("FAIL sto_after we=%b mem9=%0h wdata=%0h need 0,a5,0", bus.mem_we, mem[9], bus.mem_wdata);
    end
  endtask

  task automatic test_jmp();
    do_reset();
    load_ir(8'hFE);
    bus.ld_pc = 1'b1;
    tick();
    clear_strobes();
    vectors++;
    if (pc_dbg !== 5'h1E || bus.opcode !== 3'b111) begin
      miscompares++;
      $display("FAIL jmp_load pc=%0h op=%0d need 1e,7", pc_dbg, bus.opcode);
    end
    set_pc(5'd3);
    load_ir(8'h10);
    bus.ld_pc = 1'b1; bus.inc_pc = 1'b1;
    tick();
    clear_strobes();
    vectors++;
    if (pc_dbg !== 5'h10) begin
      miscompares++;
      $display("FAIL jmp_priority pc=%0h need 10", pc_dbg);
    end
    set_pc(5'd31);
    bus.inc_pc = 1'b1;
    tick();
    clear_strobes();
    vectors++;
    if (pc_dbg !== 5'd0) begin
      miscompares++;
      $display("FAIL pc_wrap pc=%0h need 0", pc_dbg);
    end
  endtask

  task automatic test_skz();
    do_reset();
    load_ac(8'h00);
    vectors++;
    if (bus.zero !== 1'b1) begin
      miscompares++;
      $display("FAIL skz_zero_flag got %b need 1", bus.zero);
    end
    set_pc(5'd4);
    mem[4] = 8'h20;
    run_instr();
    vectors++;
    if (pc_dbg !== 5'd6) begin
      miscompares++;
      $display("FAIL skz_taken pc=%0d need 6", pc_dbg);
    end
    load_ac(8'h01);
    vectors++;
    if (bus.zero !== 1'b0) begin
      miscompares++;
      $display("FAIL skz_nonzero_flag got %b need 0", bus.zero);
    end
    set_pc(5'd4);
    mem[4] = 8'h20;
    run_instr();
    vectors++;
    if (pc_dbg !== 5'd5) begin
      miscompares++;
      $display("FAIL skz_not_taken pc=%0d need 5", pc_dbg);
    end
  endtask

  task automatic test_halt();
    do_reset();
    mem[0] = 8'h00;
    run_instr();
    vectors++;
    if (halted !== 1'b1 || bus.phase !== 3'd4 || pc_dbg !== 5'd1) begin
      miscompares++;
      $display("FAIL halt_enter halted=%b phase=%0d pc=%0d need 1,4,1", halted, bus.phase, pc_dbg);
    end
    for (int i = 0; i < 20; i++) begin
      bus.ld_ac = 1'b1; bus.ld_pc = 1'b1; bus.wr = 1'b1; bus.rd = 1'b1;
      bus.ld_ir = 1'b1; bus.inc_pc = 1'b1; bus.sel = 1'($urandom_range(0, 1));
      #1;
      vectors++;
      if (bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_mem_gate cycle %0d we=%b re=%b need 0,0", i, bus.mem_we, bus.mem_re);
      end
      tick();
      vectors++;
      if (bus.phase !== 3'd4 || pc_dbg !== 5'd1 || ac_dbg !== 8'd0 || halted !== 1'b1) begin
        miscompares++;
        $display("FAIL halt_freeze cycle %0d phase=%0d pc=%0d ac=%0h halted=%b need 4,1,0,1",
                 i, bus.phase, pc_dbg, ac_dbg, halted);
      end
    end
    clear_strobes();
    do_reset();
    #1;
    vectors++;
    if (halted !== 1'b0 || bus.phase !== 3'd0) begin
      miscompares++;
      $display("FAIL halt_clear halted=%b phase=%0d need 0,0", halted, bus.phase);
    end
  endtask

  task automatic test_random();
    logic [4:0] e_addr;
    do_reset();
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    for (int n = 0; n < 400; n++) begin
      if (m_halted && $urandom_range(0, 7) == 0) do_reset();
      bus.sel = 1'($urandom); bus.rd = 1'($urandom); bus.ld_ir = 1'($urandom);
      bus.inc_pc = 1'($urandom); bus.ld_ac = 1'($urandom); bus.ld_pc = 1'($urandom);
      bus.wr = 1'($urandom); bus.data_e = 1'($urandom);
      bus.halt = ($urandom_range(0, 39) == 0);
      #1;
      e_addr = bus.sel ? 5'(m_pc) : 5'(m_ir % 32);
      vectors++;
      if (bus.mem_addr !== e_addr || bus.mem_we !== (bus.wr & !m_halted) ||
          bus.mem_re !== (bus.rd & !m_halted) ||
          bus.mem_wdata !== (bus.data_e ? 8'(m_ac) : 8'h00)) begin
        miscompares++;
        $display("FAIL rand_comb n=%0d addr=%0d we=%b re=%b wdata=%0h need addr %0d",
                 n, bus.mem_addr, bus.mem_we, bus.mem_re, bus.mem_wdata, e_addr);
      end
      tick();
      vectors++;
      if (bus.phase !== 3'(m_phase) || pc_dbg !== 5'(m_pc) || ac_dbg !== 8'(m_ac) ||
          halted !== m_halted || bus.opcode !== 3'(m_ir / 32) || bus.zero !== (m_ac == 0)) begin
        miscompares++;
        $display("FAIL rand_state n=%0d phase=%0d pc=%0d ac=%0h halted=%b op=%0d need %0d,%0d,%0h,%b,%0d",
                 n, bus.phase, pc_dbg, ac_dbg, halted, bus.opcode,
                 m_phase, m_pc, m_ac, m_halted, m_ir / 32);
      end
    end
    clear_strobes();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    clear_strobes();
    model_reset();
    #7;
    test_reset();
    test_add();
    test_sto();
    test_jmp();
    test_skz();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
